// File: rtl/axi_lite_csr_bank_if.sv
// AXI4-Lite slave-side bundle for the CSR bank: five channels with master/slave views.
interface axi_lite_csr_bank_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_csr_bank.sv
// AXI4-Lite CSR bank: byte-strobed RW registers followed by sampled RO status registers,
// with per-register commit/read strobes for the voice engine config logic.
module axi_lite_csr_bank #(
   parameter int unsigned            C_DATA_WIDTH = 32,
   parameter int unsigned            C_NUM_RW_REG = 34,
   parameter int unsigned            C_NUM_RO_REG = 2,
   parameter logic [C_DATA_WIDTH-1:0] C_RST_VAL   = '0,
   parameter int unsigned            C_ADDR_WIDTH = $clog2(C_NUM_RW_REG + C_NUM_RO_REG) + 2
) (
   input  logic                                 s_axi_aclk,
   input  logic                                 s_axi_aresetn,
   axi_lite_csr_bank_if.slave                   s_axi,
   output logic [C_NUM_RW_REG*C_DATA_WIDTH-1:0] rw_regs_out,
   input  logic [C_NUM_RO_REG*C_DATA_WIDTH-1:0] ro_regs_in,
   output logic [C_NUM_RW_REG-1:0]              wr_pulse,
   output logic [C_NUM_RO_REG-1:0]              rd_pulse
);

   localparam int unsigned NUM_REG = C_NUM_RW_REG + C_NUM_RO_REG;
   localparam int unsigned IDX_W   = C_ADDR_WIDTH - 2;
   localparam int unsigned STRB_W  = C_DATA_WIDTH / 8;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   typedef logic [C_NUM_RW_REG-1:0][C_DATA_WIDTH-1:0] rw_arr_t;
   typedef logic [C_NUM_RO_REG-1:0][C_DATA_WIDTH-1:0] ro_arr_t;

   // write path state
   logic                    aw_held_q, aw_held_d;
   logic                    w_held_q, w_held_d;
   logic [IDX_W-1:0]        awidx_q, awidx_d;
   logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [C_NUM_RW_REG-1:0] wr_pulse_q, wr_pulse_d;
   rw_arr_t                 regs_q, regs_d;

   // read path state
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [C_NUM_RO_REG-1:0] rd_pulse_q, rd_pulse_d;

   ro_arr_t          ro_c;
   logic             aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0] ridx;
   logic             unused_c;

   assign ro_c     = ro_regs_in;
   assign aw_hs    = s_axi.awvalid & awready_q;
   assign w_hs     = s_axi.wvalid & wready_q;
   assign ar_hs    = s_axi.arvalid & arready_q;
   assign commit   = aw_held_q & w_held_q;
   assign ridx     = s_axi.araddr[C_ADDR_WIDTH-1:2];
   assign unused_c = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   // next-state for both channels; the read path samples regs_q so a same-edge write is not visible
   always_comb begin
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rd_pulse_d = '0;

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (32'(awidx_q) < C_NUM_RW_REG) begin
            bresp_d = RESP_OKAY;
            for (int unsigned k = 0; k < C_NUM_RW_REG; k++) begin
               if (32'(awidx_q) == k) begin
                  wr_pulse_d[k] = 1'b1;
                  for (int unsigned b = 0; b < STRB_W; b++) begin
                     if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                  end
               end
            end
         end else if (32'(awidx_q) < NUM_REG) begin
            bresp_d = RESP_SLVERR;
         end else begin
            bresp_d = RESP_DECERR;
         end
      end else begin
         if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
         if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi.awaddr[C_ADDR_WIDTH-1:2];
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
         end
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         if (32'(ridx) < C_NUM_RW_REG) begin
            rresp_d = RESP_OKAY;
            for (int unsigned k = 0; k < C_NUM_RW_REG; k++) begin
               if (32'(ridx) == k) rdata_d = regs_q[k];
            end
         end else if (32'(ridx) < NUM_REG) begin
            rresp_d = RESP_OKAY;
            for (int unsigned m = 0; m < C_NUM_RO_REG; m++) begin
               if (32'(ridx) == C_NUM_RW_REG + m) begin
                  rdata_d       = ro_c[m];
                  rd_pulse_d[m] = 1'b1;
               end
            end
         end else begin
            rresp_d = RESP_DECERR;
         end
      end else if (rvalid_q && s_axi.rready) begin
         rvalid_d = 1'b0;
         rdata_d  = '0;
      end

      // readies stay low until the first edge after reset release
      awready_d = ~aw_held_d & ~bvalid_d;
      wready_d  = ~w_held_d & ~bvalid_d;
      arready_d = ~rvalid_d;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awidx_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         wr_pulse_q <= '0;
         regs_q     <= {C_NUM_RW_REG{C_RST_VAL}};
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rd_pulse_q <= '0;
      end else begin
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awidx_q    <= awidx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign rw_regs_out   = regs_q;
   assign wr_pulse      = wr_pulse_q;
   assign rd_pulse      = rd_pulse_q;

endmodule

// File: tb/tb_axi_lite_csr_bank.sv
// Bench for axi_lite_csr_bank: directed corner sequences, a vector table, and random traffic
// checked against an array model of the register map.
module tb_axi_lite_csr_bank;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 34;
   localparam int unsigned RO = 2;
   localparam int unsigned NREG = RW + RO;
   localparam int unsigned AW = 8;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi_lite_csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();
   logic [RW*DW-1:0] rw_regs_out;
   logic [RO*DW-1:0] ro_regs_in;
   logic [RW-1:0]    wr_pulse;
   logic [RO-1:0]    rd_pulse;

   axi_lite_csr_bank #(
      .C_DATA_WIDTH(DW), .C_NUM_RW_REG(RW), .C_NUM_RO_REG(RO),
      .C_RST_VAL('0), .C_ADDR_WIDTH(AW)
   ) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .s_axi(s_axi),
      .rw_regs_out(rw_regs_out), .ro_regs_in(ro_regs_in),
      .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] m_regs [RW];
   logic [DW-1:0] ro_val [RO];

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [3:0]    strb;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
   } vec_t;
   vec_t tbl [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] reg_of(input int k);
      return rw_regs_out[DW*k +: DW];
   endfunction

   task automatic set_ro(input int m, input logic [DW-1:0] v);
      ro_val[m] = v;
      ro_regs_in[DW*m +: DW] = v;
   endtask

   // reference model: map rules stated directly on register indices
   function automatic logic [1:0] exp_resp(input int idx, input bit wr);
      if (idx < int'(RW)) return OKAY;
      if (idx < int'(NREG)) return wr ? SLVERR : OKAY;
      return DECERR;
   endfunction

   task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
      if (idx < int'(RW))
         for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   function automatic logic [DW-1:0] model_read(input int idx);
      if (idx < int'(RW)) return m_regs[idx];
      if (idx < int'(NREG)) return ro_val[idx - int'(RW)];
      return '0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < int'(RW); k++) m_regs[k] = '0;
   endtask

   task automatic bus_idle();
      s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
      s_axi.wdata = '0;  s_axi.wstrb = '0;  s_axi.wvalid = 1'b0;
      s_axi.bready = 1'b0;
      s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b0;
   endtask

   // full write transaction; called and returns at a negedge
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp, output logic [RW-1:0] pulse);
      bit aw_done = 0, w_done = 0, aw_f, w_f;
      int cyc = 0;
      s_axi.awaddr = addr; s_axi.awprot = 3'($urandom);
      s_axi.wdata = data;  s_axi.wstrb = strb;
      while (!(aw_done && w_done) && cyc < 100) begin
         if (!aw_done && cyc >= aw_dly) s_axi.awvalid = 1'b1;
         if (!w_done && cyc >= w_dly) s_axi.wvalid = 1'b1;
         aw_f = s_axi.awvalid && s_axi.awready;
         w_f  = s_axi.wvalid && s_axi.wready;
         @(negedge clk); cyc++;
         if (aw_f) begin s_axi.awvalid = 1'b0; aw_done = 1; end
         if (w_f) begin s_axi.wvalid = 1'b0; w_done = 1; end
      end
      chk("aw_w_accept", {aw_done, w_done}, 2'b11);
      cyc = 0;
      while (!s_axi.bvalid && cyc < 20) begin @(negedge clk); cyc++; end
      chk("bvalid_seen", s_axi.bvalid, 1'b1);
      resp = s_axi.bresp;
      pulse = wr_pulse;
      repeat (b_dly) @(negedge clk);
      s_axi.bready = 1'b1;
      @(negedge clk);
      s_axi.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input int r_dly, output logic [DW-1:0] data,
                           output logic [1:0] resp, output logic [RO-1:0] rdp);
      int cyc = 0;
      s_axi.araddr = addr; s_axi.arprot = 3'($urandom); s_axi.arvalid = 1'b1;
      while (!s_axi.arready && cyc < 20) begin @(negedge clk); cyc++; end
      chk("ar_accept", s_axi.arready, 1'b1);
      @(negedge clk);
      s_axi.arvalid = 1'b0;
      chk("rvalid_latency", s_axi.rvalid, 1'b1);
      data = s_axi.rdata; resp = s_axi.rresp; rdp = rd_pulse;
      repeat (r_dly) @(negedge clk);
      s_axi.rready = 1'b1;
      @(negedge clk);
      s_axi.rready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #2 rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] resp;
      logic [RW-1:0] pulse, ep;
      logic [RO-1:0] rdp, erp;
      logic [DW-1:0] rd;
      logic [AW-1:0] a;
      int idx;

      bus_idle();
      set_ro(0, '0); set_ro(1, '0);
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // reset state and ready release timing
      chk("rst_awready", s_axi.awready, 1'b0);
      chk("rst_wready", s_axi.wready, 1'b0);
      chk("rst_arready", s_axi.arready, 1'b0);
      chk("rst_bvalid", s_axi.bvalid, 1'b0);
      chk("rst_rvalid", s_axi.rvalid, 1'b0);
      chk("rst_reg0", reg_of(0), 0);
      chk("rst_reg33", reg_of(33), 0);
      rst_n = 1'b1;
      #1 chk("rel_awready_first", s_axi.awready, 1'b0);
      @(negedge clk);
      chk("rel_awready", s_axi.awready, 1'b1);
      chk("rel_wready", s_axi.wready, 1'b1);
      chk("rel_arready", s_axi.arready, 1'b1);

      // W first, AW three cycles later, then B held off for five cycles
      s_axi.wdata = 32'hDEADBEEF; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
      @(negedge clk); s_axi.wvalid = 1'b0;
      chk("w_only_wready_low", s_axi.wready, 1'b0);
      repeat (2) @(negedge clk);
      s_axi.awaddr = 8'h08; s_axi.awvalid = 1'b1;
      chk("late_awready", s_axi.awready, 1'b1);
      @(negedge clk); s_axi.awvalid = 1'b0;
      chk("lat_bvalid_n1", s_axi.bvalid, 1'b0);
      chk("lat_reg2_n1", reg_of(2), 0);
      @(negedge clk);
      chk("lat_bvalid_n2", s_axi.bvalid, 1'b1);
      chk("lat_bresp", s_axi.bresp, OKAY);
      chk("lat_reg2_n2", reg_of(2), 32'hDEADBEEF);
      chk("lat_wr_pulse", wr_pulse, 34'h4);
      m_regs[2] = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bhold_bvalid", s_axi.bvalid, 1'b1);
         chk("bhold_awready", s_axi.awready, 1'b0);
         chk("bhold_wready", s_axi.wready, 1'b0);
         chk("bhold_pulse", wr_pulse, 0);
      end
      s_axi.bready = 1'b1; @(negedge clk); s_axi.bready = 1'b0;
      chk("bdone_bvalid", s_axi.bvalid, 1'b0);
      chk("bdone_awready", s_axi.awready, 1'b1);

      // RO read held with rready low while the status input moves
      set_ro(0, 32'h5A5A0001);
      s_axi.araddr = 8'h88; s_axi.arvalid = 1'b1;
      @(negedge clk); s_axi.arvalid = 1'b0;
      chk("ro_rvalid", s_axi.rvalid, 1'b1);
      chk("ro_rdata", s_axi.rdata, 32'h5A5A0001);
      chk("ro_rresp", s_axi.rresp, OKAY);
      chk("ro_rd_pulse", rd_pulse, 2'b01);
      chk("ro_arready_low", s_axi.arready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_ro(0, $urandom);
         @(negedge clk);
         chk("ro_hold_rdata", s_axi.rdata, 32'h5A5A0001);
         chk("ro_hold_pulse", rd_pulse, 2'b00);
      end
      s_axi.rready = 1'b1; @(negedge clk); s_axi.rready = 1'b0;
      chk("ro_done_rvalid", s_axi.rvalid, 1'b0);
      chk("ro_done_rdata", s_axi.rdata, 0);
      chk("ro_done_arready", s_axi.arready, 1'b1);

      // read on the commit edge of a write to the same register sees the old value
      axi_write(8'h14, 32'h55555555, 4'hF, 0, 0, 0, resp, pulse);
      s_axi.awaddr = 8'h14; s_axi.wdata = 32'h66666666; s_axi.wstrb = 4'hF;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
      @(negedge clk); s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      s_axi.araddr = 8'h14; s_axi.arvalid = 1'b1;
      @(negedge clk); s_axi.arvalid = 1'b0;
      chk("raw_rdata_old", s_axi.rdata, 32'h55555555);
      chk("raw_bvalid", s_axi.bvalid, 1'b1);
      chk("raw_reg5_new", reg_of(5), 32'h66666666);
      s_axi.bready = 1'b1; s_axi.rready = 1'b1;
      @(negedge clk); s_axi.bready = 1'b0; s_axi.rready = 1'b0;

      // reset with a response pending, then with only AW held
      s_axi.awaddr = 8'h04; s_axi.wdata = 32'h77; s_axi.wstrb = 4'hF;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
      @(negedge clk); s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      @(negedge clk);
      chk("pre_rst_bvalid", s_axi.bvalid, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_bvalid", s_axi.bvalid, 1'b0);
      chk("mid_rst_reg1", reg_of(1), 0);
      chk("mid_rst_reg2", reg_of(2), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      s_axi.awaddr = 8'h0C; s_axi.awvalid = 1'b1;
      @(negedge clk); s_axi.awvalid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      s_axi.wdata = 32'h99999999; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
      @(negedge clk); s_axi.wvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stale_aw_bvalid", s_axi.bvalid, 1'b0);
      chk("stale_aw_reg3", reg_of(3), 0);
      chk("stale_aw_pulse", wr_pulse, 0);
      do_reset();

      // vector table
      set_ro(0, 32'h13579BDF); set_ro(1, 32'h2468ACE0);
      tbl[0]  = '{1'b1, 8'h00, 32'h11223344, 4'hF, OKAY,   32'h0};
      tbl[1]  = '{1'b1, 8'h00, 32'hAABBCCDD, 4'h5, OKAY,   32'h0};
      tbl[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, OKAY,   32'h11BB33DD};
      tbl[3]  = '{1'b1, 8'h84, 32'hCAFEF00D, 4'hF, OKAY,   32'h0};
      tbl[4]  = '{1'b0, 8'h84, 32'h0,        4'h0, OKAY,   32'hCAFEF00D};
      tbl[5]  = '{1'b1, 8'h88, 32'h12345678, 4'hF, SLVERR, 32'h0};
      tbl[6]  = '{1'b1, 8'hFC, 32'h12345678, 4'hF, DECERR, 32'h0};
      tbl[7]  = '{1'b1, 8'h90, 32'h12345678, 4'hF, DECERR, 32'h0};
      tbl[8]  = '{1'b0, 8'hFC, 32'h0,        4'h0, DECERR, 32'h0};
      tbl[9]  = '{1'b0, 8'h90, 32'h0,        4'h0, DECERR, 32'h0};
      tbl[10] = '{1'b1, 8'h0B, 32'h01020304, 4'h3, OKAY,   32'h0};
      tbl[11] = '{1'b0, 8'h08, 32'h0,        4'h0, OKAY,   32'h00000304};
      tbl[12] = '{1'b1, 8'h04, 32'hFFFFFFFF, 4'h0, OKAY,   32'h0};
      tbl[13] = '{1'b0, 8'h04, 32'h0,        4'h0, OKAY,   32'h0};
      tbl[14] = '{1'b0, 8'h8E, 32'h0,        4'h0, OKAY,   32'h2468ACE0};
      tbl[15] = '{1'b0, 8'h8A, 32'h0,        4'h0, OKAY,   32'h13579BDF};
      tbl[16] = '{1'b0, 8'h01, 32'h0,        4'h0, OKAY,   32'h11BB33DD};
      for (int i = 0; i < 17; i++) begin
         a = tbl[i].addr;
         idx = int'(a[7:2]);
         if (tbl[i].is_wr) begin
            axi_write(a, tbl[i].data, tbl[i].strb, i % 3, (i + 1) % 3, i % 2, resp, pulse);
            ep = '0;
            if (tbl[i].resp == OKAY) ep[idx] = 1'b1;
            chk($sformatf("tbl%0d_bresp", i), resp, tbl[i].resp);
            chk($sformatf("tbl%0d_wr_pulse", i), pulse, ep);
            model_write(idx, tbl[i].data, tbl[i].strb);
         end else begin
            axi_read(a, i % 3, rd, resp, rdp);
            erp = '0;
            if (idx >= int'(RW) && idx < int'(NREG)) erp[idx - int'(RW)] = 1'b1;
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("tbl%0d_rresp", i), resp, tbl[i].resp);
            chk($sformatf("tbl%0d_rd_pulse", i), rdp, erp);
         end
      end

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         set_ro(0, $urandom); set_ro(1, $urandom);
         idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(36, 63)) : int'($urandom_range(0, 35));
         a = {6'(idx), 2'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            logic [DW-1:0] d;
            logic [3:0] s;
            d = $urandom; s = 4'($urandom);
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                      resp, pulse);
            ep = '0;
            if (idx < int'(RW)) ep[idx] = 1'b1;
            model_write(idx, d, s);
            chk("rnd_bresp", resp, exp_resp(idx, 1'b1));
            chk("rnd_wr_pulse", pulse, ep);
            if (idx < int'(RW)) chk($sformatf("rnd_reg%0d", idx), reg_of(idx), m_regs[idx]);
         end else begin
            axi_read(a, $urandom_range(0, 3), rd, resp, rdp);
            erp = '0;
            if (idx >= int'(RW) && idx < int'(NREG)) erp[idx - int'(RW)] = 1'b1;
            chk($sformatf("rnd_rdata_idx%0d", idx), rd, model_read(idx));
            chk("rnd_rresp", resp, exp_resp(idx, 1'b0));
            chk("rnd_rd_pulse", rdp, erp);
         end
      end

      for (int k = 0; k < int'(RW); k++) chk($sformatf("final_reg%0d", k), reg_of(k), m_regs[k]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
